dds_wavegen: RTL and testbench
==============================

DDS_WAVEGEN -- requirements
Module: dds_wavegen

Interface
REQ-001 Parameter OUT_W, default 10, sample width in bits, unsigned offset-binary; legal range 4..16.
REQ-002 Parameter PHASE_W, default 16, phase accumulator width; SHALL satisfy PHASE_W >= max(OUT_W+1, LUT_ADDR_W+2).
REQ-003 Parameter LUT_ADDR_W, default 7, quarter-wave LUT address width (2^LUT_ADDR_W entries).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 en  input  1  advance phase accumulator this cycle.
REQ-007 tune_word  input  PHASE_W  frequency tuning word, captured only on tune_load.
REQ-008 tune_load  input  1  capture tune_word into internal tune register.
REQ-009 mode  input  2  waveform: 0 sine, 1 triangle, 2 sawtooth, 3 square.
REQ-010 sample  output  OUT_W  waveform sample, registered.
REQ-011 sample_valid  output  1  sample corresponds to an en cycle.
REQ-012 wrap  output  1  one-cycle pulse on accumulator overflow.

Function
REQ-013 On en=1, phase SHALL become (phase + tune_reg) mod 2^PHASE_W; on en=0 phase SHALL hold.
REQ-014 tune_load=1 SHALL update tune_reg at the clock edge; an accumulation in the same cycle SHALL use the previous tune_reg.
REQ-015 wrap SHALL be 1 in the cycle after an en cycle whose addition carries out of PHASE_W bits, else 0.
REQ-016 Pipeline: stage 1 registers the quadrant-corrected LUT address, quadrant and mode from the current phase; stage 2 registers sample; sample reflects the phase register value 2 cycles earlier.
REQ-017 Pipeline stages SHALL advance every cycle; sample_valid SHALL equal en delayed by 2 cycles.
REQ-018 Sine: quadrant q = phase[PHASE_W-1:PHASE_W-2]; idx = next LUT_ADDR_W bits; idx SHALL be bit-inverted for q=1 and q=3.
REQ-019 LUT entry i = round((2^(OUT_W-1)-1) * sin(pi/2 * (i+0.5)/2^LUT_ADDR_W)), generated at elaboration.
REQ-020 Sine output SHALL be 2^(OUT_W-1) + lut for q=0,1 and 2^(OUT_W-1)-1-lut for q=2,3; full range 0..2^OUT_W-1, no overflow.
REQ-021 Sawtooth output SHALL be phase[PHASE_W-1 -: OUT_W].
REQ-022 Triangle output SHALL be phase[PHASE_W-2 -: OUT_W] when phase MSB=0, its bitwise inverse when MSB=1.
REQ-023 Square output SHALL be 2^OUT_W-1 when phase MSB=0, 0 when MSB=1.
REQ-024 A mode change SHALL take effect on the sample 2 cycles later without disturbing phase, tune_reg or sample_valid.
REQ-025 tune_reg=0 with en=1 SHALL hold phase constant, with sample_valid still asserted.

Reset
REQ-026 While rst_n=0 at a clock edge: phase=0, tune_reg=0, pipeline registers=0, sample=2^(OUT_W-1), sample_valid=0, wrap=0.
REQ-027 Reset SHALL override en and tune_load in the same cycle; reset mid-operation discards in-flight samples.
REQ-028 First valid sample after release with en=1 held SHALL appear 2 cycles after the first en edge and SHALL correspond to phase 0.

Configuration
REQ-029 Macro DDS_AMPLITUDE_EN: when defined, an input amp (8 bits, unsigned) is added and a third pipeline stage computes sample = 2^(OUT_W-1) + ((raw - 2^(OUT_W-1)) * amp) >>> 8 (signed, arithmetic shift); latency and sample_valid delay become 3; reset value of stage 3 = 2^(OUT_W-1).
REQ-030 When DDS_AMPLITUDE_EN is undefined, the amp port does not exist and latency is 2 as in REQ-016.

Verification (OUT_W=10, PHASE_W=16, LUT_ADDR_W=7)
REQ-031 Reset, load tune_word=0x0080, mode=0, en=1 -> first valid sample 515, then 521; 512-sample period; min 0, max 1023; sample_valid rises 2 cycles after en.
REQ-032 tune_word=0x0400, mode=2 -> sawtooth 0,16,32,...; wrap pulses once every 64 en cycles.
REQ-033 tune_word=0x8000, mode=3 -> sample alternates 1023,0; wrap pulses on every second en cycle.
REQ-034 en toggled 1,0,0,1 with tune 0x0080 -> phase holds during en=0, sample repeats, sample_valid follows en delayed 2.
REQ-035 tune_load with a new word and rst_n=0 in the same cycle -> tune_reg=0, phase=0, sample=512, sample_valid=0 next cycle.
REQ-036 With DDS_AMPLITUDE_EN, amp=128, sine mode -> samples span 256..767 (+/-1), latency 3.

Source files
------------

// File: rtl/dds_wavegen.sv
// dds_wavegen: direct digital synthesis waveform generator (sine/triangle/saw/square).
// Latency: 2 cycles from phase register to sample (3 with DDS_AMPLITUDE_EN defined).
// Backpressure: none; the pipeline advances every cycle, sample_valid marks en-driven samples.
//
// Ports:
//   clk, rst_n          single clock, synchronous active-low reset
//   en                  advance the phase accumulator this cycle
//   tune_word/tune_load frequency tuning word and its capture strobe
//   mode                0 sine, 1 triangle, 2 sawtooth, 3 square
//   amp                 8-bit amplitude scale (only when DDS_AMPLITUDE_EN is defined)
//   sample/sample_valid registered offset-binary sample and its qualifier
//   wrap                one-cycle pulse after an accumulator carry-out
//
// Build option: define DDS_AMPLITUDE_EN to add the amp input and a scaling stage.

module dds_wavegen #(
    parameter int OUT_W      = 10,
    parameter int PHASE_W    = 16,
    parameter int LUT_ADDR_W = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] tune_word,
    input  logic               tune_load,
    input  logic [1:0]         mode,
`ifdef DDS_AMPLITUDE_EN
    input  logic [7:0]         amp,
`endif
    output logic [OUT_W-1:0]   sample,
    output logic               sample_valid,
    output logic               wrap
);

    localparam int              LUT_N = 1 << LUT_ADDR_W;
    localparam logic [OUT_W-1:0] MID  = {1'b1, {(OUT_W-1){1'b0}}};
    localparam real             PI    = 3.14159265358979323846;
    localparam real             AMP_R = real'((1 << (OUT_W-1)) - 1);

    // Taylor series sine for elaboration-time table generation; the
    // argument never exceeds pi/2, where 12 terms are far below 1 LSB.
    function automatic real sin_r(input real x);
        real term;
        real acc;
        term = x;
        acc  = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / ((2.0 * k) * (2.0 * k + 1.0));
            acc  = acc + term;
        end
        return acc;
    endfunction

    // Quarter-wave table sampled at bin centres, so the mirrored quadrants
    // line up without a duplicated peak or zero entry.
    logic [OUT_W-2:0] lut_rom [LUT_N];

    for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
        localparam real ANG = PI / 2.0 * (real'(gi) + 0.5) / real'(LUT_N);
        localparam int  VAL = $rtoi(AMP_R * sin_r(ANG) + 0.5);
        assign lut_rom[gi] = VAL[OUT_W-2:0];
    end

    // Accumulator state
    logic [PHASE_W-1:0]    phase_q, phase_d;
    logic [PHASE_W-1:0]    tune_q, tune_d;
    logic                  wrap_q, wrap_d;
    logic [PHASE_W:0]      phase_sum;

    // Stage 1: quadrant-corrected address, quadrant, mode and the phase
    // bits just below the quadrant (needed by the non-sine shapes).
    logic [LUT_ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic [1:0]            s1_quad_q, s1_quad_d;
    logic [1:0]            s1_mode_q, s1_mode_d;
    logic [OUT_W-2:0]      s1_frac_q, s1_frac_d;
    logic                  s1_vld_q, s1_vld_d;
    logic [LUT_ADDR_W-1:0] s1_idx;

    // Stage 2: waveform sample
    logic [OUT_W-1:0]      s2_smp_q, s2_smp_d;
    logic                  s2_vld_q, s2_vld_d;
    logic [OUT_W-2:0]      s2_lut;

    always_comb begin
        phase_sum = {1'b0, phase_q} + {1'b0, tune_q};
        phase_d   = en ? phase_sum[PHASE_W-1:0] : phase_q;
        wrap_d    = en & phase_sum[PHASE_W];
        // The accumulator adds the old tune value even when a load lands
        // on the same edge.
        tune_d    = tune_load ? tune_word : tune_q;

        s1_quad_d = phase_q[PHASE_W-1 -: 2];
        s1_idx    = phase_q[PHASE_W-3 -: LUT_ADDR_W];
        // Quadrants 1 and 3 run the quarter-wave backwards.
        s1_addr_d = s1_quad_d[0] ? ~s1_idx : s1_idx;
        s1_frac_d = phase_q[PHASE_W-3 -: OUT_W-1];
        s1_mode_d = mode;
        s1_vld_d  = en;

        s2_lut    = lut_rom[s1_addr_q];
        s2_vld_d  = s1_vld_q;
        s2_smp_d  = MID;
        case (s1_mode_q)
            2'd0: begin
                // Upper half: MID + lut. Lower half: (MID-1) - lut, which
                // is simply the bit-inverse of lut under a cleared MSB.
                s2_smp_d = s1_quad_q[1] ? {1'b0, ~s2_lut} : {1'b1, s2_lut};
            end
            2'd1: begin
                s2_smp_d = s1_quad_q[1] ? ~{s1_quad_q[0], s1_frac_q}
                                        :  {s1_quad_q[0], s1_frac_q};
            end
            2'd2: begin
                s2_smp_d = {s1_quad_q, s1_frac_q[OUT_W-2:1]};
            end
            default: begin
                s2_smp_d = {OUT_W{~s1_quad_q[1]}};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q   <= '0;
            tune_q    <= '0;
            wrap_q    <= 1'b0;
            s1_addr_q <= '0;
            s1_quad_q <= '0;
            s1_mode_q <= '0;
            s1_frac_q <= '0;
            s1_vld_q  <= 1'b0;
            s2_smp_q  <= MID;
            s2_vld_q  <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            tune_q    <= tune_d;
            wrap_q    <= wrap_d;
            s1_addr_q <= s1_addr_d;
            s1_quad_q <= s1_quad_d;
            s1_mode_q <= s1_mode_d;
            s1_frac_q <= s1_frac_d;
            s1_vld_q  <= s1_vld_d;
            s2_smp_q  <= s2_smp_d;
            s2_vld_q  <= s2_vld_d;
        end
    end

`ifdef DDS_AMPLITUDE_EN
    // Stage 3: scale the excursion about mid-scale by amp/256.
    logic [OUT_W-1:0]        s3_smp_q, s3_smp_d;
    logic                    s3_vld_q, s3_vld_d;
    logic signed [OUT_W:0]   s3_diff;
    logic signed [OUT_W+9:0] s3_prod;
    logic signed [OUT_W+9:0] s3_scl;

    always_comb begin
        s3_diff  = $signed({1'b0, s2_smp_q}) - $signed({1'b0, MID});
        s3_prod  = s3_diff * $signed({1'b0, amp});
        s3_scl   = s3_prod >>> 8;
        // |scaled| <= |diff|, so the mod-2^OUT_W sum cannot overflow.
        s3_smp_d = MID + s3_scl[OUT_W-1:0];
        s3_vld_d = s2_vld_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s3_smp_q <= MID;
            s3_vld_q <= 1'b0;
        end else begin
            s3_smp_q <= s3_smp_d;
            s3_vld_q <= s3_vld_d;
        end
    end

    assign sample       = s3_smp_q;
    assign sample_valid = s3_vld_q;
`else
    assign sample       = s2_smp_q;
    assign sample_valid = s2_vld_q;
`endif

    assign wrap = wrap_q;

endmodule

// File: tb/tb_dds_wavegen.sv
// tb_dds_wavegen: self-checking bench for dds_wavegen (default parameters).
// Latency: model expects samples 2 edges after the phase they come from.
// Backpressure: none; inputs are driven on the falling edge.

module tb_dds_wavegen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] tune_word;
    logic        tune_load;
    logic [1:0]  mode;
    logic [9:0]  sample;
    logic        sample_valid;
    logic        wrap;
`ifdef DDS_AMPLITUDE_EN
    logic [7:0]  amp;
    initial amp = 8'd255;
`endif

    dds_wavegen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .tune_word    (tune_word),
        .tune_load    (tune_load),
        .mode         (mode),
`ifdef DDS_AMPLITUDE_EN
        .amp          (amp),
`endif
        .sample       (sample),
        .sample_valid (sample_valid),
        .wrap         (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Ideal waveform value for a given mode and 16-bit phase.
    function automatic int wave(input int md, input int ph);
        int  q;
        int  idx;
        int  lut;
        int  t;
        real a;
        case (md)
            0: begin
                q   = ph >> 14;
                idx = (ph >> 7) & 127;
                if (q % 2 == 1) idx = 127 - idx;
                a   = 511.0 * $sin(3.14159265358979323846 * (real'(idx) + 0.5) / 256.0);
                lut = $rtoi(a + 0.5);
                return (q < 2) ? 512 + lut : 511 - lut;
            end
            1: begin
                t = (ph >> 5) & 1023;
                return ((ph >> 15) != 0) ? 1023 - t : t;
            end
            2: return ph >> 6;
            default: return ((ph >> 15) != 0) ? 0 : 1023;
        endcase
    endfunction

    // Behavioural model: phase/tune as integers, outputs as a 2-deep delay
    // of ideal waveform values.
    int m_phase = 0;
    int m_tune  = 0;
    int pend_s  = 0;
    bit pend_v  = 0;
    bit pend_k  = 0;
    int exp_s   = 512;
    bit exp_v   = 0;
    bit exp_k   = 0;
    bit exp_w   = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_tune  = 0;
            exp_s   = 512;
            exp_v   = 0;
            exp_k   = 1;
            exp_w   = 0;
            pend_v  = 0;
            pend_k  = 0;
        end else begin
            exp_s  = pend_s;
            exp_v  = pend_v;
            exp_k  = pend_k;
            pend_s = wave(int'(mode), m_phase);
            pend_v = en;
            pend_k = 1;
            exp_w  = en && (m_phase + m_tune >= 65536);
            if (en) m_phase = (m_phase + m_tune) % 65536;
            if (tune_load) m_tune = int'(tune_word);
        end
    end

    always @(negedge clk) begin
        chk("model_valid", int'(sample_valid), int'(exp_v));
        chk("model_wrap", int'(wrap), int'(exp_w));
        if (exp_k) chk("model_sample", int'(sample), exp_s);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    int smp [1024];
    int mn;
    int mx;
    int bad;
    int s_hold;
    int nwrap;
    int last_w;
    int gap;

    initial begin
        rst_n = 1'b0; en = 1'b0; tune_load = 1'b0; tune_word = '0; mode = 2'd0;
        repeat (3) cyc();
        chk("reset_sample", int'(sample), 512);
        chk("reset_valid", int'(sample_valid), 0);
        chk("reset_wrap", int'(wrap), 0);

        // Sine, tune 0x0080
        rst_n = 1'b1; tune_load = 1'b1; tune_word = 16'h0080;
        cyc();
        tune_load = 1'b0; en = 1'b1;
        cyc();
        chk("sine_valid_lag", int'(sample_valid), 0);
        cyc();
        chk("sine_first_valid", int'(sample_valid), 1);
        chk("sine_first", int'(sample), 515);
        cyc();
        chk("sine_second", int'(sample), 521);
        mn = 1023; mx = 0;
        for (int i = 0; i < 1024; i++) begin
            cyc();
            smp[i] = int'(sample);
            if (smp[i] < mn) mn = smp[i];
            if (smp[i] > mx) mx = smp[i];
        end
        bad = 0;
        for (int i = 0; i < 512; i++) if (smp[i] != smp[i+512]) bad++;
        chk("sine_period_512", bad, 0);
        chk("sine_min", mn, 0);
        chk("sine_max", mx, 1023);

        // en pattern 1,0,0,1: phase holds, sample repeats
        en = 1'b0; cyc();
        en = 1'b0; cyc();
        chk("hold_valid0", int'(sample_valid), 0);
        s_hold = int'(sample);
        en = 1'b1; cyc();
        chk("hold_valid1", int'(sample_valid), 0);
        chk("hold_repeat1", int'(sample), s_hold);
        cyc();
        chk("hold_valid_back", int'(sample_valid), 1);
        chk("hold_repeat2", int'(sample), s_hold);

        // Mode sweep with mid-stream tune loads (model-checked)
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            tune_word = 16'(16'h0123 + m * 16'h0411);
            tune_load = 1'b1; cyc();
            tune_load = 1'b0;
            repeat (40) cyc();
        end

        // Sawtooth, tune 0x0400
        rst_n = 1'b0; en = 1'b0; cyc();
        rst_n = 1'b1; tune_load = 1'b1; tune_word = 16'h0400; mode = 2'd2;
        cyc();
        tune_load = 1'b0; en = 1'b1;
        cyc(); cyc();
        chk("saw_0", int'(sample), 0);
        cyc();
        chk("saw_16", int'(sample), 16);
        cyc();
        chk("saw_32", int'(sample), 32);
        nwrap = 0; last_w = -1; gap = 0;
        for (int i = 0; i < 128; i++) begin
            cyc();
            if (wrap) begin
                if (last_w >= 0) gap = i - last_w;
                last_w = i;
                nwrap++;
            end
        end
        chk("saw_wrap_count", nwrap, 2);
        chk("saw_wrap_gap", gap, 64);

        // Square, tune 0x8000
        rst_n = 1'b0; en = 1'b0; cyc();
        rst_n = 1'b1; tune_load = 1'b1; tune_word = 16'h8000; mode = 2'd3;
        cyc();
        tune_load = 1'b0; en = 1'b1;
        cyc(); cyc();
        chk("sq_hi", int'(sample), 1023);
        cyc();
        chk("sq_lo", int'(sample), 0);
        cyc();
        chk("sq_hi2", int'(sample), 1023);
        nwrap = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (wrap) nwrap++;
        end
        chk("sq_wrap_count", nwrap, 5);

        // Reset wins over tune_load and en in the same cycle
        mode = 2'd0;
        rst_n = 1'b0; tune_load = 1'b1; tune_word = 16'h1234; en = 1'b1;
        cyc();
        chk("rst_load_sample", int'(sample), 512);
        chk("rst_load_valid", int'(sample_valid), 0);
        chk("rst_load_wrap", int'(wrap), 0);
        rst_n = 1'b1; tune_load = 1'b0;
        repeat (4) cyc();
        chk("zero_tune_valid", int'(sample_valid), 1);
        chk("zero_tune_sample", int'(sample), 515);
        repeat (4) cyc();
        chk("zero_tune_hold", int'(sample), 515);
        chk("zero_tune_wrap", int'(wrap), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
